// File: rtl/block_scheduler.sv
// block_scheduler: raster-order 8x8 block sequencer issuing 64 sample addresses per block.
// Optional stall counter output enabled by defining BLOCK_SCHED_STALL_CNT_EN.
module block_scheduler #(
  parameter int COL_BLOCKS = 40,
  parameter int ROW_BLOCKS = 30,
  parameter int LINE_WIDTH = 320,
  parameter int ADDR_W     = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_address,
  input  logic              addr_ready,
  input  logic              blk_done,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [5:0]        sample_idx,
  output logic [5:0]        col_idx,
  output logic [4:0]        row_idx,
  output logic              block_start,
  output logic              busy,
  output logic              frame_done
`ifdef BLOCK_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [5:0] col_n, sidx_n;
  logic [4:0] row_n;
  logic bs_n, last_col, last_row;
  logic [31:0] addr_full;
  assign last_col   = col_idx == 6'(COL_BLOCKS - 1);
  assign last_row   = row_idx == 5'(ROW_BLOCKS - 1);
  assign addr_valid = state == FETCH;
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;
  // abort wins over start/ready/blk_done, so indices freeze where they were
  always_comb begin
    state_n = state;
    base_n  = base;
    col_n   = col_idx;
    row_n   = row_idx;
    sidx_n  = sample_idx;
    bs_n    = 1'b0;
    if (abort) state_n = IDLE;
    else
      case (state)
        IDLE: if (start) begin
          state_n = FETCH;
          base_n  = base_address;
          col_n   = '0;
          row_n   = '0;
          sidx_n  = '0;
          bs_n    = 1'b1;
        end
        FETCH: if (addr_ready) begin
          sidx_n  = sample_idx + 6'd1;
          state_n = sample_idx == 6'd63 ? WAIT : FETCH;
        end
        WAIT: if (blk_done) begin
          state_n = last_col && last_row ? DONE : FETCH;
          bs_n    = !(last_col && last_row);
          col_n   = last_col ? '0 : col_idx + 6'd1;
          row_n   = last_col && !last_row ? row_idx + 5'd1 : row_idx;
        end
        default: state_n = IDLE;
      endcase
    addr_full = 32'(base_n) + 32'(row_n) * 32'(8 * LINE_WIDTH)
              + 32'(sidx_n[5:3]) * 32'(LINE_WIDTH)
              + 32'({col_n, 3'b000}) + 32'(sidx_n[2:0]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      col_idx     <= '0;
      row_idx     <= '0;
      sample_idx  <= '0;
      sample_addr <= '0;
      block_start <= 1'b0;
    end else begin
      state       <= state_n;
      base        <= base_n;
      col_idx     <= col_n;
      row_idx     <= row_n;
      sample_idx  <= sidx_n;
      sample_addr <= addr_full[ADDR_W-1:0];
      block_start <= bs_n;
    end
  end
`ifdef BLOCK_SCHED_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || (state == IDLE && start && !abort)) stall_cnt <= '0;
    else if (addr_valid && !addr_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_block_scheduler.sv
// tb_block_scheduler: directed self-checking bench for block_scheduler at default geometry.
module tb_block_scheduler;
  logic        clock = 1'b0;
  logic        reset, start, abort, addr_ready, blk_done;
  logic [17:0] base_address;
  logic        addr_valid, block_start, busy, frame_done;
  logic [17:0] sample_addr;
  logic [5:0]  sample_idx, col_idx;
  logic [4:0]  row_idx;
`ifdef BLOCK_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int vectors = 0;
  int miscompares = 0;

  block_scheduler dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .base_address(base_address), .addr_ready(addr_ready), .blk_done(blk_done),
    .addr_valid(addr_valid), .sample_addr(sample_addr), .sample_idx(sample_idx),
    .col_idx(col_idx), .row_idx(row_idx), .block_start(block_start),
    .busy(busy), .frame_done(frame_done)
`ifdef BLOCK_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; blk_done = 1'b0; addr_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [17:0] b);
    base_address = b; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    int cyc;
    do_reset;
    vectors++;
    if ({addr_valid, sample_addr, sample_idx, col_idx, row_idx, block_start, busy, frame_done} !== '0) begin
      miscompares++; $display("FAIL reset_values: got %h required 0", {addr_valid, sample_addr, sample_idx, col_idx, row_idx, block_start, busy, frame_done});
    end
    addr_ready = 1'b1;
    pulse_start(18'h00400);
    cyc = 0;
    while (sample_idx != 6'd20 && cyc < 100) begin tick; cyc++; end
    vectors++;
    if (sample_idx !== 6'd20) begin miscompares++; $display("FAIL reach_sample20: got %0d required 20", sample_idx); end
    reset = 1'b1;
    tick;
    vectors++;
    if ({addr_valid, sample_addr, sample_idx, col_idx, row_idx, block_start, busy, frame_done} !== '0) begin
      miscompares++; $display("FAIL midfetch_reset: got %h required 0", {addr_valid, sample_addr, sample_idx, col_idx, row_idx, block_start, busy, frame_done});
    end
`ifdef BLOCK_SCHED_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt); end
`endif
    reset = 1'b0;
    pulse_start(18'h0);
    vectors++;
    if ({block_start, addr_valid, sample_idx, col_idx, row_idx, sample_addr} !== {1'b1, 1'b1, 6'd0, 6'd0, 5'd0, 18'd0}) begin
      miscompares++; $display("FAIL restart_after_reset: got bs=%b v=%b s=%0d c=%0d r=%0d a=%0d required 1 1 0 0 0 0", block_start, addr_valid, sample_idx, col_idx, row_idx, sample_addr);
    end
    abort = 1'b1; tick; abort = 1'b0;
  endtask

  task automatic test_first_block;
    int cyc;
    do_reset;
    addr_ready = 1'b1;
    pulse_start(18'h0);
    cyc = 0;
    while (addr_valid && cyc < 200) begin
      if (sample_idx == 6'd0 || sample_idx == 6'd9 || sample_idx == 6'd63) begin
        vectors++;
        if (sample_addr !== (sample_idx == 6'd0 ? 18'd0 : sample_idx == 6'd9 ? 18'd321 : 18'd2247)) begin
          miscompares++; $display("FAIL first_block_addr s=%0d: got %0d", sample_idx, sample_addr);
        end
      end
      tick; cyc++;
    end
    vectors++;
    if (cyc !== 64) begin miscompares++; $display("FAIL first_block_beats: got %0d required 64", cyc); end
    vectors++;
    if ({addr_valid, busy, frame_done} !== 3'b010) begin miscompares++; $display("FAIL wait_state: got %b required 010", {addr_valid, busy, frame_done}); end
    abort = 1'b1; tick; abort = 1'b0;
    vectors++;
    if ({addr_valid, busy, frame_done} !== 3'b000) begin miscompares++; $display("FAIL abort_from_wait: got %b required 000", {addr_valid, busy, frame_done}); end
  endtask

  task automatic test_stall;
    int cyc, beats, exp_s, stalls;
    logic r;
    logic [17:0] exp_a;
    do_reset;
    stalls = 0;
    pulse_start(18'h0);
    for (int b = 0; b < 2; b++) begin
      cyc = 0; beats = 0; exp_s = 0;
      while (addr_valid && cyc < 1000) begin
        exp_a = 18'(b * 8 + (exp_s / 8) * 320 + exp_s % 8);
        vectors++;
        if (sample_idx !== 6'(exp_s) || sample_addr !== exp_a) begin
          miscompares++; $display("FAIL stall_hold b=%0d: got s=%0d a=%0d required s=%0d a=%0d", b, sample_idx, sample_addr, exp_s, exp_a);
        end
        r = cyc == 0 ? 1'b0 : ($urandom_range(0, 9) >= 3);
        addr_ready = r;
        if (r) beats++; else stalls++;
        tick; cyc++;
        if (r) exp_s++;
      end
      vectors++;
      if (beats !== 64) begin miscompares++; $display("FAIL stall_beats b=%0d: got %0d required 64", b, beats); end
      if (b == 0) begin
        blk_done = 1'b1; tick; blk_done = 1'b0;
        vectors++;
        if ({block_start, col_idx, row_idx, sample_addr} !== {1'b1, 6'd1, 5'd0, 18'd8}) begin
          miscompares++; $display("FAIL next_block: got bs=%b c=%0d r=%0d a=%0d required 1 1 0 8", block_start, col_idx, row_idx, sample_addr);
        end
      end
    end
`ifdef BLOCK_SCHED_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 16'(stalls)) begin miscompares++; $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, stalls); end
`endif
    abort = 1'b1; tick; abort = 1'b0;
  endtask

  task automatic test_full_frame;
    int cyc, starts, dones, pc, pr, rowchk;
    logic [17:0] last;
    do_reset;
    addr_ready = 1'b1; blk_done = 1'b1;
    pulse_start(18'h01000);
    cyc = 0; starts = 0; dones = 0; rowchk = 0; pc = 0; pr = 0; last = '0;
    while (cyc < 90000) begin
      if (block_start) starts++;
      if (frame_done) dones++;
      if (addr_valid) last = sample_addr;
      if (block_start && col_idx == 6'd0 && row_idx == 5'd1) begin
        rowchk++;
        vectors++;
        if (sample_addr !== 18'h01000 + 18'd2560 || pc != 39 || pr != 0) begin
          miscompares++; $display("FAIL row_wrap: got a=%0d prev c=%0d r=%0d required %0d 39 0", sample_addr, pc, pr, 4096 + 2560);
        end
      end
      if (!busy) break;
      pc = int'(col_idx); pr = int'(row_idx);
      tick; cyc++;
    end
    blk_done = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL frame_timeout: busy=%b after %0d cycles required 0", busy, cyc); end
    vectors++;
    if (starts !== 1200) begin miscompares++; $display("FAIL block_starts: got %0d required 1200", starts); end
    vectors++;
    if (dones !== 1) begin miscompares++; $display("FAIL frame_done_count: got %0d required 1", dones); end
    vectors++;
    if (last !== 18'd80895) begin miscompares++; $display("FAIL last_addr: got %0d required 80895", last); end
    vectors++;
    if (rowchk !== 1) begin miscompares++; $display("FAIL row_wrap_seen: got %0d required 1", rowchk); end
  endtask

  task automatic test_abort;
    int cyc, dones;
    do_reset;
    addr_ready = 1'b1; blk_done = 1'b1;
    pulse_start(18'h0);
    cyc = 0; dones = 0;
    while (!(!addr_valid && busy && col_idx == 6'd5 && row_idx == 5'd3) && cyc < 20000) begin
      if (frame_done) dones++;
      tick; cyc++;
    end
    vectors++;
    if ({addr_valid, busy, col_idx, row_idx} !== {1'b0, 1'b1, 6'd5, 5'd3}) begin
      miscompares++; $display("FAIL reach_wait_5_3: got v=%b b=%b c=%0d r=%0d required 0 1 5 3", addr_valid, busy, col_idx, row_idx);
    end
    abort = 1'b1; tick; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (frame_done) dones++;
      vectors++;
      if ({addr_valid, busy, block_start, col_idx} !== {1'b0, 1'b0, 1'b0, 6'd5}) begin
        miscompares++; $display("FAIL post_abort i=%0d: got v=%b b=%b bs=%b c=%0d required 0 0 0 5", i, addr_valid, busy, block_start, col_idx);
      end
      tick;
    end
    vectors++;
    if (dones !== 0) begin miscompares++; $display("FAIL abort_frame_done: got %0d required 0", dones); end
    blk_done = 1'b0;
    pulse_start(18'h0);
    vectors++;
    if ({block_start, addr_valid, sample_idx, col_idx, row_idx, sample_addr} !== {1'b1, 1'b1, 6'd0, 6'd0, 5'd0, 18'd0}) begin
      miscompares++; $display("FAIL restart_after_abort: got bs=%b v=%b s=%0d c=%0d r=%0d a=%0d required 1 1 0 0 0 0", block_start, addr_valid, sample_idx, col_idx, row_idx, sample_addr);
    end
    abort = 1'b1; tick; abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0; blk_done = 1'b0; base_address = '0;
    test_reset;
    test_first_block;
    test_stall;
    test_full_frame;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
